// File: rtl/capture_readout_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// capture_readout_sequencer
//
// Runs one acquisition between the sampler/trigger path and the UART
// transmitter. While armed it writes every sampler strobe into an external
// circular sample RAM. After the trigger it stores delay_count more samples
// and then freezes the buffer. It then reads the buffer back newest-first and
// streams each sample to the UART, LSB byte first, using the tx_busy
// handshake.
//
// Ports
//   clock        : system clock, rising edge
//   reset        : asynchronous, active-low reset
//   arm          : one-cycle pulse that starts a new capture; aborts any readout
//   run          : trigger-fired level from the trigger block
//   sample_valid : sampler strobe (the RAM takes its data straight from the sampler)
//   read_count   : number of samples to send back
//   delay_count  : number of post-trigger samples to store
//   wr_en        : sample RAM write enable
//   wr_addr      : sample RAM write address
//   rd_addr      : sample RAM read address (RAM read latency is one cycle)
//   rd_data      : sample RAM read data
//   tx_byte      : byte presented to the UART
//   tx_start     : one-cycle UART transmit request
//   tx_busy      : UART busy
//   capturing    : high while armed or collecting post-trigger samples
//   sending      : high during readout
//   done         : one-cycle pulse when readout completes
//
// SAMPLE_WIDTH must be a multiple of 8. ADDR_WIDTH must be 15 or less so that
// the fill level (up to DEPTH) fits the 16-bit sample counters.
// -----------------------------------------------------------------------------
module capture_readout_sequencer #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    run,
  input  logic                    sample_valid,
  input  logic [15:0]             read_count,
  input  logic [15:0]             delay_count,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [SAMPLE_WIDTH-1:0] rd_data,
  output logic [7:0]              tx_byte,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic                    capturing,
  output logic                    sending,
  output logic                    done
);

  localparam int                  NUM_BYTES = SAMPLE_WIDTH / 8;
  localparam logic [7:0]          LAST_BYTE = 8'(NUM_BYTES - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [3:0] {
    IDLE, ARMED, DELAY, RD_ADDR, RD_WAIT, SEND, WAIT_HI, WAIT_LO, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     fill_q, fill_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_d;
  logic [15:0]             delay_cnt_q;
  logic [15:0]             remain_q;
  logic [15:0]             fill_ext;
  logic [15:0]             first_n;
  logic [SAMPLE_WIDTH-1:0] sample_q;
  logic [SAMPLE_WIDTH-1:0] sample_shifted;
  logic [7:0]              byte_idx_q;
  logic                    delay_hit;
  logic                    trig_now;
  logic                    enter_readout;
  logic                    last_byte;

  // ---------------------------------------------------------------------------
  // Helper terms shared by the next-state logic and the datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    wr_addr_d     = wr_addr;
    fill_d        = fill_q;
    delay_hit     = 1'b0;
    trig_now      = 1'b0;
    enter_readout = 1'b0;
    fill_ext      = 16'd0;
    first_n       = 16'd0;

    if (wr_en) begin
      wr_addr_d = wr_addr + 1'b1;
      if (fill_q != DEPTH) fill_d = fill_q + 1'b1;
    end

    // Immediate trigger: the sample written in the trigger cycle is included.
    trig_now  = (state_q == ARMED) && run && (delay_count == 16'd0);
    // The write that brings the post-trigger count to delay_count ends capture.
    delay_hit = (state_q == DELAY) && wr_en && ((delay_cnt_q + 16'd1) == delay_count);
    enter_readout = !arm && (trig_now || delay_hit);

    // fill never exceeds DEPTH, so this min also applies the DEPTH clamp.
    fill_ext = 16'(fill_d);
    first_n  = (read_count < fill_ext) ? read_count : fill_ext;
  end

  assign last_byte = (byte_idx_q == LAST_BYTE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    // NOTE: sequential state always uses non-blocking assignment so every
    // flop samples pre-edge values regardless of process ordering.
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic; arm overrides everything
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ARMED:   if (run) state_d = (delay_count == 16'd0) ? RD_ADDR : DELAY;
        DELAY:   if (delay_hit) state_d = RD_ADDR;
        // remain_q can only be zero here on the first entry (empty request).
        RD_ADDR: state_d = (remain_q == 16'd0) ? DONE : RD_WAIT;
        RD_WAIT: state_d = SEND;
        SEND:    if (!tx_busy) state_d = WAIT_HI;
        // The UART may raise busy several cycles after the request.
        WAIT_HI: if (tx_busy) state_d = WAIT_LO;
        WAIT_LO: begin
          if (!tx_busy) begin
            if (!last_byte)              state_d = SEND;
            else if (remain_q == 16'd1)  state_d = DONE;
            else                         state_d = RD_ADDR;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: write pointer, fill level, counters, read pointer, sample latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_addr     <= '0;
      fill_q      <= '0;
      delay_cnt_q <= '0;
      remain_q    <= '0;
      rd_addr     <= '0;
      sample_q    <= '0;
      byte_idx_q  <= '0;
    end else if (arm) begin
      wr_addr     <= '0;
      fill_q      <= '0;
      delay_cnt_q <= '0;
      remain_q    <= '0;
      byte_idx_q  <= '0;
    end else begin
      wr_addr <= wr_addr_d;
      fill_q  <= fill_d;

      if ((state_q == DELAY) && wr_en) delay_cnt_q <= delay_cnt_q + 16'd1;

      if (enter_readout) begin
        remain_q <= first_n;
        // Newest sample sits just behind the post-write pointer.
        rd_addr  <= wr_addr_d - 1'b1;
      end

      case (state_q)
        RD_WAIT: begin
          sample_q   <= rd_data;
          byte_idx_q <= '0;
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (last_byte) begin
              rd_addr  <= rd_addr - 1'b1;
              remain_q <= remain_q - 16'd1;
            end else begin
              byte_idx_q <= byte_idx_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sample_shifted = sample_q >> {byte_idx_q, 3'b000};

  always_comb begin
    capturing = (state_q == ARMED) || (state_q == DELAY);
    sending   = (state_q == RD_ADDR) || (state_q == RD_WAIT) || (state_q == SEND) ||
                (state_q == WAIT_HI) || (state_q == WAIT_LO);
    done      = (state_q == DONE);
    // arm wins over a pending write or transmit in the same cycle.
    wr_en     = capturing && sample_valid && !arm;
    tx_start  = (state_q == SEND) && !tx_busy && !arm;
    tx_byte   = sample_shifted[7:0];
  end

endmodule

// File: tb/tb_capture_readout_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_capture_readout_sequencer
//
// Randomized bench with a scoreboard. The stimulus side drives captures and,
// from the samples it knows were accepted, pushes the expected byte stream
// (newest sample first, LSB byte first) into a queue. A monitor pops and
// compares on every tx_start. A small sample RAM and a UART with random busy
// latency/length are modelled here.
// -----------------------------------------------------------------------------
module tb_capture_readout_sequencer;

  localparam int SW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  localparam int MODE_RAND  = 0;
  localparam int MODE_SEQ   = 1;
  localparam int MODE_CONST = 2;

  logic          clock;
  logic          reset;
  logic          arm;
  logic          run;
  logic          sample_valid;
  logic [15:0]   read_count;
  logic [15:0]   delay_count;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [SW-1:0] rd_data;
  logic [7:0]    tx_byte;
  logic          tx_start;
  logic          tx_busy;
  logic          capturing;
  logic          sending;
  logic          done;

  logic [SW-1:0] sample_data;
  logic [SW-1:0] mem [DEPTH];

  logic [7:0]    exp_q[$];
  int            checks   = 0;
  int            errors   = 0;
  int            tx_seen  = 0;
  int            done_cnt = 0;

  capture_readout_sequencer #(
    .SAMPLE_WIDTH(SW),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .arm         (arm),
    .run         (run),
    .sample_valid(sample_valid),
    .read_count  (read_count),
    .delay_count (delay_count),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .tx_byte     (tx_byte),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .capturing   (capturing),
    .sending     (sending),
    .done        (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Synchronous sample RAM, one-cycle read latency.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rd_data = '0;
  end

  always @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= sample_data;
    rd_data <= mem[rd_addr];
  end

  // UART: takes a request at the edge, raises busy 0..3 cycles later, holds 1..5.
  initial begin
    int lat;
    int len;
    tx_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (tx_start) begin
        @(posedge clock);
        if (reset) begin
          lat = $urandom_range(0, 3);
          len = $urandom_range(1, 5);
          repeat (lat) @(posedge clock);
          #1 tx_busy = 1'b1;
          repeat (len) @(posedge clock);
          #1 tx_busy = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop on every transmit request.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (reset && tx_start) begin
        tx_seen++;
        check("tx_start while busy", {31'd0, tx_busy}, 32'd0);
        check("sending during tx_start", {31'd0, sending}, 32'd1);
        check("tx_start expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tx_byte", {24'd0, tx_byte}, {24'd0, e});
        end
      end
      if (reset && wr_en) check("wr_en only while capturing", {31'd0, capturing}, 32'd1);
      if (reset && done) done_cnt++;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [SW-1:0] sample_for(input int mode, input int i);
    if (mode == MODE_SEQ)   return SW'(i);
    if (mode == MODE_CONST) return 16'h1234;
    return SW'($urandom);
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, " wr_en"},     {31'd0, wr_en},     32'd0);
    check({tag, " wr_addr"},   {28'd0, wr_addr},   32'd0);
    check({tag, " rd_addr"},   {28'd0, rd_addr},   32'd0);
    check({tag, " tx_byte"},   {24'd0, tx_byte},   32'd0);
    check({tag, " tx_start"},  {31'd0, tx_start},  32'd0);
    check({tag, " capturing"}, {31'd0, capturing}, 32'd0);
    check({tag, " sending"},   {31'd0, sending},   32'd0);
    check({tag, " done"},      {31'd0, done},      32'd0);
  endtask

  task automatic wait_done(input int d0);
    for (int c = 0; c < 20000; c++) begin
      if (done_cnt > d0) break;
      tick();
    end
    check("done pulse seen", {31'd0, done_cnt > d0}, 32'd1);
  endtask

  // Expected readout: the last min(read_count, accepted, DEPTH) samples, newest first.
  task automatic push_expected(input logic [SW-1:0] written[$], input int rdc);
    int n;
    logic [SW-1:0] s;
    n = rdc;
    if (written.size() < n) n = written.size();
    if (DEPTH < n) n = DEPTH;
    for (int k = 0; k < n; k++) begin
      s = written[written.size() - 1 - k];
      for (int b = 0; b < SW / 8; b++) exp_q.push_back(s[b*8 +: 8]);
    end
  endtask

  // Arms, feeds n_pre strobes, triggers, feeds dly strobes; returns accepted samples.
  task automatic fill_and_trigger(input int n_pre, input int dly, input int rdc,
                                  input int mode, input bit trig_strobe,
                                  output logic [SW-1:0] written[$]);
    logic [SW-1:0] s;
    written.delete();
    arm = 1'b1; run = 1'b0; sample_valid = 1'b0;
    read_count = 16'(rdc); delay_count = 16'(dly);
    tick();
    arm = 1'b0;
    for (int i = 0; i < n_pre; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      s = sample_for(mode, i);
      sample_data = s; sample_valid = 1'b1; written.push_back(s);
      tick();
      sample_valid = 1'b0;
    end
    run = 1'b1;
    if (trig_strobe) begin
      s = sample_for(mode, n_pre);
      sample_data = s; sample_valid = 1'b1; written.push_back(s);
    end
    tick();
    sample_valid = 1'b0;
    for (int i = 0; i < dly; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      s = sample_for(mode, n_pre + 1 + i);
      sample_data = s; sample_valid = 1'b1; written.push_back(s);
      tick();
      sample_valid = 1'b0;
    end
  endtask

  task automatic capture(input int n_pre, input int dly, input int rdc,
                         input int mode, input bit trig_strobe);
    logic [SW-1:0] written[$];
    int d0;
    d0 = done_cnt;
    fill_and_trigger(n_pre, dly, rdc, mode, trig_strobe, written);
    push_expected(written, rdc);
    // Strobes during readout must be ignored.
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'($urandom);
      sample_data  = SW'($urandom);
      tick();
    end
    sample_valid = 1'b0;
    wait_done(d0);
    run = 1'b0;
    check("all expected bytes sent", exp_q.size(), 32'd0);
    exp_q.delete();
    @(negedge clock);
    check("done is one cycle", {31'd0, done}, 32'd0);
    tick();
  endtask

  task automatic zero_read_test();
    logic [SW-1:0] written[$];
    fill_and_trigger(3, 0, 0, MODE_RAND, 1'b0, written);
    // Back to the trigger cycle's timeline: the trigger was sampled on the
    // edge just passed, so the DUT is now in its first cycle after trigger.
    check("zero read: done 1 cycle after trigger", {31'd0, done}, 32'd0);
    @(negedge clock);
    check("zero read: done 1 cycle after trigger (mid)", {31'd0, done}, 32'd0);
    @(negedge clock);
    check("zero read: done 2 cycles after trigger", {31'd0, done}, 32'd1);
    @(negedge clock);
    check("zero read: done drops", {31'd0, done}, 32'd0);
    run = 1'b0;
    tick();
  endtask

  task automatic abort_test();
    logic [SW-1:0] written[$];
    int base;
    fill_and_trigger(10, 0, 8, MODE_RAND, 1'b0, written);
    push_expected(written, 8);
    base = tx_seen;
    for (int c = 0; c < 5000; c++) begin
      if (tx_seen >= base + 4) break;
      tick();
    end
    check("abort: two samples sent first", {31'd0, tx_seen >= base + 4}, 32'd1);
    exp_q.delete();
    arm = 1'b1; run = 1'b0;
    tick();
    arm = 1'b0;
    @(negedge clock);
    check("abort: capturing next cycle", {31'd0, capturing}, 32'd1);
    check("abort: wr_addr cleared",      {28'd0, wr_addr},   32'd0);
    check("abort: sending dropped",      {31'd0, sending},   32'd0);
    base = tx_seen;
    repeat (60) tick();
    check("abort: no further tx_start", tx_seen - base, 32'd0);
  endtask

  task automatic reset_test();
    logic [SW-1:0] written[$];
    bit hit;
    fill_and_trigger(6, 0, 4, MODE_RAND, 1'b0, written);
    push_expected(written, 4);
    hit = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock);
      if (tx_start) begin
        hit = 1'b1;
        break;
      end
    end
    check("reset test: reached SEND", {31'd0, hit}, 32'd1);
    #1 reset = 1'b0;
    exp_q.delete();
    #1 check_outputs_zero("reset in SEND");
    run = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (40) tick();
    check("after reset: idle capturing", {31'd0, capturing}, 32'd0);
    check("after reset: idle sending",   {31'd0, sending},   32'd0);
  endtask

  initial begin
    int rdc;
    reset = 1'b0; arm = 1'b0; run = 1'b0; sample_valid = 1'b0;
    sample_data = '0; read_count = '0; delay_count = '0;
    repeat (2) @(posedge clock);
    #1 check_outputs_zero("reset");
    @(negedge clock);
    reset = 1'b1;
    tick();

    capture(20, 0, 16, MODE_SEQ, 1'b0);     // wrap: 19 down to 4
    capture(3, 2, 10, MODE_RAND, 1'b0);     // E,D,C,B,A
    capture(1, 0, 1, MODE_CONST, 1'b0);     // 0x34 then 0x12
    zero_read_test();
    abort_test();
    reset_test();

    for (int t = 0; t < 12; t++) begin
      rdc = ($urandom_range(0, 3) == 0) ? 1000 : $urandom_range(0, 20);
      capture($urandom_range(0, 24), $urandom_range(0, 5), rdc, MODE_RAND,
              1'($urandom_range(0, 1)));
    end

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
